// File: rtl/timer_counter.sv
// Prescaled up/down timer with load, auto-reload and sticky overflow, underflow
// and compare-match flags. All state lives in the clk domain.
module timer_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PSC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       clk_sel,
  input  logic [WIDTH-1:0] start_counter,
  input  logic [WIDTH-1:0] compare_val,
  input  logic             up_down,
  input  logic             load,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             clr_overflow,
  input  logic             clr_underflow,
  input  logic             clr_compare,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             overflow,
  output logic             underflow,
  output logic             compare_match
);

  localparam logic [WIDTH-1:0] MaxVal  = '1;
  localparam logic [31:0]      SelMax  = 32'(PSC_W - 1);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] tick_mask;
  logic [31:0]      sel_ext;
  logic [31:0]      sel_eff;

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             cmp_q, cmp_d;
  logic             step;
  logic             ovf_set, udf_set, cmp_set;

  // Prescaler: free-running, never reset by a clk_sel change.
  assign psc_d   = psc_q + PSC_W'(1);
  assign sel_ext = {30'b0, clk_sel};
  assign sel_eff = (sel_ext > SelMax) ? SelMax : sel_ext;

  always_comb begin
    tick_mask = '0;
    for (int i = 0; i < int'(PSC_W); i++) begin
      if (32'(i) <= sel_eff) tick_mask[i] = 1'b1;
    end
  end

  // All selected low bits of psc set; psc==0 keeps tick low during reset.
  assign tick = &(psc_q | ~tick_mask);

  always_comb begin
    count_d = count_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    step    = enable && tick && !load;
    if (load) begin
      count_d = start_counter;
    end else if (step) begin
      if (up_down) begin
        if (count_q == MaxVal) begin
          count_d = auto_reload ? start_counter : '0;
          ovf_set = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = auto_reload ? start_counter : MaxVal;
          udf_set = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
    cmp_set = step && (count_d == compare_val);
    // Set beats a simultaneous clear.
    ovf_d = ovf_set | (ovf_q & ~clr_overflow);
    udf_d = udf_set | (udf_q & ~clr_underflow);
    cmp_d = cmp_set | (cmp_q & ~clr_compare);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      cmp_q   <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      cmp_q   <= cmp_d;
    end
  end

  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;
  assign compare_match = cmp_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus a randomized
// run compared against a cycle-level arithmetic model.
module tb_timer_counter;

  localparam int WIDTH   = 8;
  localparam int PSC_W   = 4;
  localparam int MAXV    = 255;
  localparam int PSC_MOD = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       clk_sel = '0;
  logic [WIDTH-1:0] start_counter = '0;
  logic [WIDTH-1:0] compare_val = '0;
  logic             up_down = 1'b0;
  logic             load = 1'b0;
  logic             enable = 1'b0;
  logic             auto_reload = 1'b0;
  logic             clr_overflow = 1'b0;
  logic             clr_underflow = 1'b0;
  logic             clr_compare = 1'b0;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             overflow;
  logic             underflow;
  logic             compare_match;

  int checks = 0;
  int passes = 0;

  // Reference model state
  int m_psc = 0;
  int m_count = 0;
  bit m_ovf = 0;
  bit m_udf = 0;
  bit m_cmp = 0;

  timer_counter #(
    .WIDTH(WIDTH),
    .PSC_W(PSC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_sel      (clk_sel),
    .start_counter(start_counter),
    .compare_val  (compare_val),
    .up_down      (up_down),
    .load         (load),
    .enable       (enable),
    .auto_reload  (auto_reload),
    .clr_overflow (clr_overflow),
    .clr_underflow(clr_underflow),
    .clr_compare  (clr_compare),
    .count        (count),
    .tick         (tick),
    .overflow     (overflow),
    .underflow    (underflow),
    .compare_match(compare_match)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  // Tick in the current cycle: one pulse every 2^(clk_sel+1) prescaler counts.
  function automatic bit model_tick();
    int per;
    per = 2 << clk_sel;
    return (m_psc % per) == (per - 1);
  endfunction

  task automatic model_reset();
    m_psc = 0; m_count = 0; m_ovf = 0; m_udf = 0; m_cmp = 0;
  endtask

  // Advance one clk edge with the inputs as currently driven, then settle.
  task automatic clock_edge();
    bit t;
    bit so, su, sc;
    int nxt;
    t = model_tick();
    so = 0; su = 0; sc = 0;
    nxt = m_count;
    if (load) begin
      nxt = int'(start_counter);
    end else if (enable && t) begin
      if (up_down) begin
        if (m_count == MAXV) begin
          nxt = auto_reload ? int'(start_counter) : 0;
          so = 1;
        end else nxt = m_count + 1;
      end else begin
        if (m_count == 0) begin
          nxt = auto_reload ? int'(start_counter) : MAXV;
          su = 1;
        end else nxt = m_count - 1;
      end
      sc = (nxt == int'(compare_val));
    end
    @(posedge clk);
    m_psc   = (m_psc + 1) % PSC_MOD;
    m_count = nxt;
    m_ovf   = so | (m_ovf & !clr_overflow);
    m_udf   = su | (m_udf & !clr_underflow);
    m_cmp   = sc | (m_cmp & !clr_compare);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (count !== 8'h00) $display("FAIL reset_count got=%h exp=00", count); else passes++;
    checks++; if (tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", tick); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow); else passes++;
    checks++; if (underflow !== 1'b0) $display("FAIL reset_udf got=%b exp=0", underflow); else passes++;
    checks++;
    if (compare_match !== 1'b0) $display("FAIL reset_cmp got=%b exp=0", compare_match);
    else passes++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_underflow();
    apply_reset();
    clk_sel = 2'd0; start_counter = 8'h00; up_down = 1'b0; auto_reload = 1'b0;
    compare_val = 8'h80; load = 1'b1; enable = 1'b1;
    clock_edge();
    load = 1'b0;
    clock_edge();
    checks++; if (count !== 8'hFF) $display("FAIL udf_count got=%h exp=FF", count); else passes++;
    checks++; if (underflow !== 1'b1) $display("FAIL udf_flag got=%b exp=1", underflow); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL udf_ovf got=%b exp=0", overflow); else passes++;
  endtask

  task automatic test_reset_mid();
    enable = 1'b0; start_counter = 8'h37; load = 1'b1;
    clock_edge();
    load = 1'b0;
    checks++; if (count !== 8'h37) $display("FAIL mid_pre_count got=%h exp=37", count); else passes++;
    checks++;
    if (underflow !== 1'b1) $display("FAIL mid_pre_udf got=%b exp=1", underflow); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 8'h00) $display("FAIL mid_count got=%h exp=00", count); else passes++;
    checks++; if (underflow !== 1'b0) $display("FAIL mid_udf got=%b exp=0", underflow); else passes++;
    checks++; if (tick !== 1'b0) $display("FAIL mid_tick got=%b exp=0", tick); else passes++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_overflow_reload();
    logic [7:0] seen[3];
    int n;
    bit t;
    clk_sel = 2'd0; up_down = 1'b1; auto_reload = 1'b1; compare_val = 8'h80;
    start_counter = 8'hFD; load = 1'b1; enable = 1'b0;
    clock_edge();
    start_counter = 8'h10; load = 1'b0; enable = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      t = model_tick();
      clock_edge();
      if (t) begin
        seen[n] = count;
        if (n == 1) begin
          checks++;
          if (overflow !== 1'b0) $display("FAIL ovr_early got=%b exp=0", overflow);
          else passes++;
        end
        n++;
      end
    end
    checks++; if (n != 3) $display("FAIL ovr_ticks got=%0d exp=3", n); else passes++;
    checks++; if (seen[0] !== 8'hFE) $display("FAIL ovr_t1 got=%h exp=FE", seen[0]); else passes++;
    checks++; if (seen[1] !== 8'hFF) $display("FAIL ovr_t2 got=%h exp=FF", seen[1]); else passes++;
    checks++; if (seen[2] !== 8'h10) $display("FAIL ovr_t3 got=%h exp=10", seen[2]); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovr_flag got=%b exp=1", overflow); else passes++;
    enable = 1'b0;
    repeat (5) clock_edge();
    checks++;
    if (overflow !== 1'b1) $display("FAIL ovr_sticky got=%b exp=1", overflow); else passes++;
    clr_overflow = 1'b1;
    clock_edge();
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL ovr_clr got=%b exp=0", overflow); else passes++;
  endtask

  task automatic test_prescaler();
    int ticks[$];
    int gaps_bad;
    apply_reset();
    clk_sel = 2'd2; up_down = 1'b1; enable = 1'b1; auto_reload = 1'b0;
    load = 1'b0; compare_val = 8'hF0;
    for (int k = 1; k <= 64; k++) begin
      clock_edge();
      if (tick) ticks.push_back(k);
    end
    checks++; if (count !== 8'd8) $display("FAIL psc_count got=%0d exp=8", count); else passes++;
    checks++;
    if (ticks.size() != 8) $display("FAIL psc_ntick8 got=%0d exp=8", ticks.size()); else passes++;
    gaps_bad = 0;
    for (int i = 1; i < ticks.size(); i++) if (ticks[i] - ticks[i-1] != 8) gaps_bad++;
    checks++;
    if (gaps_bad != 0) $display("FAIL psc_period8 bad_gaps=%0d exp=0", gaps_bad); else passes++;
    ticks.delete();
    clk_sel = 2'd3;
    for (int k = 65; k <= 128; k++) begin
      clock_edge();
      if (tick) ticks.push_back(k);
    end
    checks++;
    if (ticks.size() != 4) $display("FAIL psc_ntick16 got=%0d exp=4", ticks.size()); else passes++;
    gaps_bad = 0;
    for (int i = 1; i < ticks.size(); i++) if (ticks[i] - ticks[i-1] != 16) gaps_bad++;
    checks++;
    if (gaps_bad != 0) $display("FAIL psc_period16 bad_gaps=%0d exp=0", gaps_bad); else passes++;
    checks++;
    if (count !== 8'(m_count)) $display("FAIL psc_model got=%h exp=%h", count, 8'(m_count));
    else passes++;
  endtask

  task automatic test_compare();
    int n;
    bit t;
    clk_sel = 2'd0; compare_val = 8'h05; start_counter = 8'h03; up_down = 1'b1;
    auto_reload = 1'b0; enable = 1'b0; load = 1'b1; clr_compare = 1'b1;
    clock_edge();
    load = 1'b0; clr_compare = 1'b0; enable = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      t = model_tick();
      clock_edge();
      if (t) begin
        n++;
        if (n == 1) begin
          checks++;
          if (compare_match !== 1'b0) $display("FAIL cmp_early got=%b exp=0", compare_match);
          else passes++;
        end
      end
    end
    checks++; if (count !== 8'h05) $display("FAIL cmp_count got=%h exp=05", count); else passes++;
    checks++;
    if (compare_match !== 1'b1) $display("FAIL cmp_set got=%b exp=1", compare_match);
    else passes++;
    enable = 1'b0; start_counter = 8'h04; load = 1'b1;
    clock_edge();
    load = 1'b0;
    for (int i = 0; i < 4 && !model_tick(); i++) clock_edge();
    enable = 1'b1; clr_compare = 1'b1;
    clock_edge();
    clr_compare = 1'b0; enable = 1'b0;
    checks++; if (count !== 8'h05) $display("FAIL cmp_recount got=%h exp=05", count); else passes++;
    checks++;
    if (compare_match !== 1'b1) $display("FAIL cmp_setwins got=%b exp=1", compare_match);
    else passes++;
    clr_compare = 1'b1;
    clock_edge();
    clr_compare = 1'b0;
    checks++;
    if (compare_match !== 1'b0) $display("FAIL cmp_clr got=%b exp=0", compare_match);
    else passes++;
  endtask

  task automatic test_load_priority();
    clk_sel = 2'd1; up_down = 1'b1; auto_reload = 1'b0; compare_val = 8'h80;
    start_counter = 8'hFF; load = 1'b1; enable = 1'b0; clr_overflow = 1'b1;
    clock_edge();
    load = 1'b0; clr_overflow = 1'b0;
    for (int i = 0; i < 8 && !model_tick(); i++) clock_edge();
    checks++; if (tick !== 1'b1) $display("FAIL ldp_tick got=%b exp=1", tick); else passes++;
    start_counter = 8'h42; load = 1'b1; enable = 1'b1;
    clock_edge();
    load = 1'b0; enable = 1'b0;
    checks++; if (count !== 8'h42) $display("FAIL ldp_count got=%h exp=42", count); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL ldp_ovf got=%b exp=0", overflow); else passes++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(31, 0) == 0) clk_sel = 2'($urandom_range(3, 0));
      if ($urandom_range(7, 0) == 0) up_down = ~up_down;
      if ($urandom_range(63, 0) == 0) compare_val = 8'($urandom);
      if ($urandom_range(15, 0) == 0) auto_reload = ~auto_reload;
      start_counter = 8'($urandom);
      load          = ($urandom_range(15, 0) == 0);
      enable        = ($urandom_range(7, 0) != 0);
      clr_overflow  = ($urandom_range(7, 0) == 0);
      clr_underflow = ($urandom_range(7, 0) == 0);
      clr_compare   = ($urandom_range(7, 0) == 0);
      clock_edge();
      checks++;
      if (count !== 8'(m_count)) $display("FAIL rnd_count cyc=%0d got=%h exp=%h", c, count,
                                          8'(m_count));
      else passes++;
      checks++;
      if (overflow !== m_ovf) $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, overflow, m_ovf);
      else passes++;
      checks++;
      if (underflow !== m_udf) $display("FAIL rnd_udf cyc=%0d got=%b exp=%b", c, underflow, m_udf);
      else passes++;
      checks++;
      if (compare_match !== m_cmp)
        $display("FAIL rnd_cmp cyc=%0d got=%b exp=%b", c, compare_match, m_cmp);
      else passes++;
      checks++;
      if (tick !== model_tick()) $display("FAIL rnd_tick cyc=%0d got=%b exp=%b", c, tick,
                                          model_tick());
      else passes++;
    end
    load = 1'b0; enable = 1'b0;
    clr_overflow = 1'b0; clr_underflow = 1'b0; clr_compare = 1'b0;
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_reset_mid();
    test_overflow_reload();
    test_prescaler();
    test_compare();
    test_load_priority();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
